genome_sequencer: RTL and testbench
===================================

GENOME_SEQUENCER -- requirements
Module: genome_sequencer

Interface
REQ-001 SHALL have parameter PHASE_W, default 32, giving the step phase-accumulator width in bits.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port core_enable, input, 1, run request from the genome loader.
REQ-005 SHALL have port poly_freq_in, input, 32, step increment per clk.
REQ-006 SHALL have port poly_seed_in, input, 32, whitening LFSR seed.
REQ-007 SHALL have port dna_in, input, 256, genome; the first-received byte is at [255:248].
REQ-008 SHALL have port otp_en, input, 1, one-time-play policy bit.
REQ-009 SHALL have port gene_data, output, 8, the whitened genome byte.
REQ-010 SHALL have port gene_valid, output, 1, gene_data is valid.
REQ-011 SHALL have port gene_ready, input, 1, consumer accepts the byte.
REQ-012 SHALL have port gene_index, output, 5, index of the presented byte.
REQ-013 SHALL have ports seq_active, seq_done and overrun, each output, 1, status.

Function
REQ-014 SHALL implement the states IDLE, WAIT_TICK, PRESENT and DONE.
REQ-015 SHALL, in IDLE on a core_enable 0->1 edge (registered compare), snapshot dna_in, poly_freq_in, otp_en and the seed (seed 0 replaced by 32'h1), clear phase and index, and enter WAIT_TICK.
REQ-016 SHALL, each cycle outside IDLE/DONE, add the snapshotted increment to the PHASE_W-bit phase accumulator with wrap-around; the carry-out is the step tick.
REQ-017 SHALL produce no ticks when the increment is 0 (sequencer stalls in WAIT_TICK).
REQ-018 SHALL, in WAIT_TICK on a tick, register gene_data = byte[index] XOR lfsr[7:0], assert gene_valid next cycle, and enter PRESENT.
REQ-019 SHALL hold gene_data, gene_index and gene_valid stable in PRESENT until gene_valid&gene_ready.
REQ-020 SHALL, on acceptance, deassert gene_valid, advance the LFSR one step (Galois, taps 32'h80200003, shift right), and increment index.
REQ-021 SHALL, on acceptance of index 31 with otp set, zero the DNA snapshot and enter DONE; otherwise index wraps 31->0 and WAIT_TICK resumes with the LFSR continuing.
REQ-022 SHALL set overrun sticky when a tick occurs in PRESENT; the tick is dropped (no queueing); cleared only on a new start.
REQ-023 SHALL, on core_enable low in any state, enter IDLE next cycle, drop gene_valid, and keep the snapshot (zeroed only by REQ-021).
REQ-024 SHALL drive seq_active=1 in WAIT_TICK/PRESENT and seq_done=1 in DONE only; DONE is left only via REQ-023.
REQ-025 SHALL ignore dna_in/freq/seed/otp changes while not in IDLE.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force: state IDLE, gene_data 0, gene_valid 0, gene_index 0, seq_active 0, seq_done 0, overrun 0, phase 0, LFSR 32'h1, snapshot 0, edge register 0.
REQ-027 SHALL start only on an edge seen after reset; core_enable already high at reset release SHALL NOT start the sequencer.

Structure
REQ-028 SHALL place the state encodings, LFSR taps constant and the 32-byte genome length in a shared package atomik_pkg.
REQ-029 SHALL contain one sub-module, atomik_lfsr32 (seed load, step enable, 32-bit state out).

Verification
REQ-030 SHALL cover this scenario: seed 1, freq 32'h8000_0000, dna bytes 0x00..0x1F, ready=1 -> byte k appears every ~2-3 clk as k^lfsr; index 0..31 then wrap to 0 with otp=0.
REQ-031 SHALL cover this scenario: otp=1, same stimulus -> after index 31 accepted seq_done=1, valid stays 0, internal snapshot all zero.
REQ-032 SHALL cover this scenario: ready=0 for 20 clk with freq 32'h8000_0000 -> data/index stable, overrun=1, no skipped index after ready returns.
REQ-033 SHALL cover this scenario: freq 0 -> seq_active=1, gene_valid never asserts over 1000 clk.
REQ-034 SHALL cover this scenario: core_enable drop mid-PRESENT -> IDLE and gene_valid=0 next clk; re-raise restarts at index 0 with the seed reloaded.
REQ-035 SHALL cover this scenario: rst_n asserted mid-run and released with core_enable held high -> outputs at reset values, no start until a fresh 0->1 edge.

Source files
------------

// File: rtl/atomik_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | atomik_pkg : shared encodings and constants for genome_sequencer  |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
package atomik_pkg;

    localparam logic [1:0]  c_ST_IDLE      = 2'd0;
    localparam logic [1:0]  c_ST_WAIT_TICK = 2'd1;
    localparam logic [1:0]  c_ST_PRESENT   = 2'd2;
    localparam logic [1:0]  c_ST_DONE      = 2'd3;

    localparam logic [31:0] c_LFSR_TAPS    = 32'h8020_0003;
    localparam int          c_GENOME_BYTES = 32;

    // Right-shifting Galois step: the bit shifted out folds the taps back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ c_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/atomik_lfsr32.sv
`default_nettype none
// +------------------------------------------------------------------+
// | atomik_lfsr32 : 32-bit Galois whitening LFSR with seed load       |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
module atomik_lfsr32
    import atomik_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 32'h1;
        end else if (load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/genome_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | genome_sequencer : phase-paced, LFSR-whitened 32-byte genome player|
// | Revision         : 1.0                                            |
// +------------------------------------------------------------------+
module genome_sequencer
    import atomik_pkg::*;
#(
    parameter int PHASE_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         core_enable,
    input  logic [31:0]  poly_freq_in,
    input  logic [31:0]  poly_seed_in,
    input  logic [255:0] dna_in,
    input  logic         otp_en,
    output logic [7:0]   gene_data,
    output logic         gene_valid,
    input  logic         gene_ready,
    output logic [4:0]   gene_index,
    output logic         seq_active,
    output logic         seq_done,
    output logic         overrun
);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_en_q;
    logic               r_armed;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_inc;
    logic [255:0]       r_dna_snap;
    logic               r_otp;
    logic [7:0]         r_data;
    logic               r_valid;
    logic [4:0]         r_index;
    logic               r_overrun;

    logic               w_start;
    logic               w_running;
    logic [PHASE_W:0]   w_sum;
    logic               w_tick;
    logic               w_accept;
    logic               w_last;
    logic [31:0]        w_seed;
    logic [31:0]        w_lfsr;
    logic [7:0]         w_byte;

    // r_armed blocks a start until core_enable has been seen low after reset.
    assign w_start   = (r_state == c_ST_IDLE) && core_enable && r_armed && !r_en_q;
    assign w_running = (r_state == c_ST_WAIT_TICK) || (r_state == c_ST_PRESENT);
    assign w_sum     = {1'b0, r_phase} + {1'b0, r_inc};
    assign w_tick    = w_running && w_sum[PHASE_W];
    assign w_accept  = (r_state == c_ST_PRESENT) && core_enable && r_valid && gene_ready;
    assign w_last    = (r_index == 5'(c_GENOME_BYTES - 1)) && r_otp;
    assign w_seed    = (poly_seed_in == 32'h0) ? 32'h1 : poly_seed_in;
    // Byte 0 sits in the top lane, so lane offset is (31 - index) * 8.
    assign w_byte    = r_dna_snap[{~r_index, 3'b000} +: 8];

    atomik_lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_start),
        .step  (w_accept),
        .seed  (w_seed),
        .state (w_lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!core_enable) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:      if (w_start)  w_next_state = c_ST_WAIT_TICK;
                c_ST_WAIT_TICK: if (w_tick)   w_next_state = c_ST_PRESENT;
                c_ST_PRESENT:   if (w_accept) w_next_state = w_last ? c_ST_DONE : c_ST_WAIT_TICK;
                default:        w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        seq_active = w_running;
        seq_done   = (r_state == c_ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q     <= 1'b0;
            r_armed    <= 1'b0;
            r_phase    <= '0;
            r_inc      <= '0;
            r_dna_snap <= '0;
            r_otp      <= 1'b0;
            r_data     <= 8'h0;
            r_valid    <= 1'b0;
            r_index    <= 5'h0;
            r_overrun  <= 1'b0;
        end else begin
            r_en_q  <= core_enable;
            r_armed <= r_armed | ~core_enable;
            if (w_start) begin
                r_dna_snap <= dna_in;
                r_inc      <= PHASE_W'(poly_freq_in);
                r_otp      <= otp_en;
                r_phase    <= '0;
                r_index    <= 5'h0;
                r_overrun  <= 1'b0;
            end else if (w_running) begin
                r_phase <= w_sum[PHASE_W-1:0];
            end
            if (w_running && w_tick && (r_state == c_ST_PRESENT)) begin
                r_overrun <= 1'b1;
            end
            if (!core_enable) begin
                r_valid <= 1'b0;
            end else if ((r_state == c_ST_WAIT_TICK) && w_tick) begin
                r_data  <= w_byte ^ w_lfsr[7:0];
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_index <= r_index + 5'd1;
                if (w_last) begin
                    r_dna_snap <= '0;
                end
            end
        end
    end

    assign gene_data  = r_data;
    assign gene_valid = r_valid;
    assign gene_index = r_index;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_genome_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_genome_sequencer : scoreboard bench for genome_sequencer       |
// | Revision            : 1.0                                         |
// +------------------------------------------------------------------+
module tb_genome_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         core_enable = 1'b0;
    logic [31:0]  poly_freq_in = 32'h0;
    logic [31:0]  poly_seed_in = 32'h0;
    logic [255:0] dna_in = '0;
    logic         otp_en = 1'b0;
    logic [7:0]   gene_data;
    logic         gene_valid;
    logic         gene_ready = 1'b0;
    logic [4:0]   gene_index;
    logic         seq_active;
    logic         seq_done;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    genome_sequencer #(.PHASE_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_enable  (core_enable),
        .poly_freq_in (poly_freq_in),
        .poly_seed_in (poly_seed_in),
        .dna_in       (dna_in),
        .otp_en       (otp_en),
        .gene_data    (gene_data),
        .gene_valid   (gene_valid),
        .gene_ready   (gene_ready),
        .gene_index   (gene_index),
        .seq_active   (seq_active),
        .seq_done     (seq_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] gstep(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Reference: k-th accepted byte is dna[k mod 32] whitened by the seed stepped k times.
    task automatic push_expected(input logic [31:0] sd, input logic [255:0] d, input int n);
        logic [31:0] l;
        logic [7:0]  b;
        exp_t        e;
        l = (sd == 32'h0) ? 32'h1 : sd;
        for (int k = 0; k < n; k++) begin
            b      = d[255 - 8 * (k % 32) -: 8];
            e.idx  = 5'(k % 32);
            e.data = b ^ l[7:0];
            exp_q.push_back(e);
            l = gstep(l);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && gene_valid === 1'b1 && gene_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_byte");
            end else begin
                mon_e = exp_q.pop_front();
                check("gene_index", 64'(gene_index), 64'(mon_e.idx));
                check("gene_data", 64'(gene_data), 64'(mon_e.data));
            end
        end
    end

    task automatic start_run(input logic [31:0] sd, input logic [31:0] fr,
                             input logic [255:0] d, input logic o);
        @(posedge clk); #1;
        core_enable  = 1'b0;
        poly_seed_in = sd;
        poly_freq_in = fr;
        dna_in       = d;
        otp_en       = o;
        @(posedge clk); #1;
        core_enable  = 1'b1;
        @(posedge clk); #1;
        // Snapshot taken at the edge above; later changes must be ignored.
        poly_seed_in = $urandom;
        poly_freq_in = 32'h0;
        dna_in       = {8{$urandom}};
        otp_en       = ~o;
    endtask

    task automatic drain(input int budget, input bit rnd_ready);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
            if (rnd_ready) gene_ready = ($urandom_range(0, 3) != 0);
        end
        gene_ready = 1'b0;
        if (exp_q.size() != 0) begin
            fail("drain_timeout");
            exp_q.delete();
        end
    endtask

    task automatic stop_run();
        @(posedge clk); #1;
        gene_ready  = 1'b0;
        core_enable = 1'b0;
        @(posedge clk); @(negedge clk);
        check("stop_active", 64'(seq_active), 64'd0);
        check("stop_valid", 64'(gene_valid), 64'd0);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gene_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("wait_valid_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 64'(gene_data), 64'd0);
        check({tag, "_valid"}, 64'(gene_valid), 64'd0);
        check({tag, "_index"}, 64'(gene_index), 64'd0);
        check({tag, "_active"}, 64'(seq_active), 64'd0);
        check({tag, "_done"}, 64'(seq_done), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    initial begin
        logic [255:0] ramp;
        logic [255:0] d;
        logic [31:0]  sd;
        logic [31:0]  fr;
        logic [7:0]   held_data;
        logic [4:0]   held_idx;
        logic         o;
        bit           ok;
        bit           bad;
        int           nb;
        int           vcount;

        for (int k = 0; k < 32; k++) ramp[255 - 8 * k -: 8] = 8'(k);

        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ramp genome, wrap past index 31 with one-time-play off.
        gene_ready = 1'b1;
        push_expected(32'h1, ramp, 40);
        start_run(32'h1, 32'h8000_0000, ramp, 1'b0);
        gene_ready = 1'b1;
        drain(400, 1'b0);
        stop_run();

        // One-time-play: sequencer finishes after index 31.
        push_expected(32'h1, ramp, 32);
        start_run(32'h1, 32'h8000_0000, ramp, 1'b1);
        gene_ready = 1'b1;
        drain(400, 1'b0);
        gene_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("otp_done", 64'(seq_done), 64'd1);
        check("otp_active", 64'(seq_active), 64'd0);
        check("otp_valid", 64'(gene_valid), 64'd0);
        check("otp_snap_zero", 64'(dut.r_dna_snap == '0), 64'd1);
        stop_run();
        check("otp_done_cleared", 64'(seq_done), 64'd0);

        // Back-pressure: held output, sticky overrun, no skipped index.
        d  = {8{$urandom}};
        sd = $urandom;
        push_expected(sd, d, 8);
        start_run(sd, 32'h8000_0000, d, 1'b0);
        wait_valid(ok);
        held_data = gene_data;
        held_idx  = gene_index;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (gene_data !== held_data || gene_index !== held_idx || gene_valid !== 1'b1) bad = 1'b1;
        end
        check("stall_stable", 64'(bad), 64'd0);
        check("stall_overrun", 64'(overrun), 64'd1);
        gene_ready = 1'b1;
        drain(400, 1'b0);
        stop_run();
        check("overrun_sticky_idle", 64'(overrun), 64'd1);

        // Zero increment stalls forever; a new start clears overrun.
        start_run($urandom, 32'h0, {8{$urandom}}, 1'b0);
        gene_ready = 1'b1;
        @(negedge clk);
        check("start_clears_overrun", 64'(overrun), 64'd0);
        vcount = 0;
        bad    = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (gene_valid) vcount++;
            if (!seq_active) bad = 1'b1;
        end
        check("freq0_no_valid", 64'(vcount), 64'd0);
        check("freq0_active", 64'(bad), 64'd0);
        stop_run();

        // Randomized runs with random back-pressure.
        for (int r = 0; r < 4; r++) begin
            sd = (r == 0) ? 32'h0 : $urandom;
            fr = $urandom_range(32'hFFFF_FFFF, 32'h4000_0000);
            d  = {8{$urandom}};
            o  = (r % 2 == 1);
            nb = o ? 32 : 48;
            push_expected(sd, d, nb);
            start_run(sd, fr, d, o);
            drain(3000, 1'b1);
            if (o) begin
                repeat (4) @(negedge clk);
                check("rand_otp_done", 64'(seq_done), 64'd1);
            end
            stop_run();
        end

        // Enable drop while presenting, then restart from index 0 with new seed.
        start_run(32'h1234_5678, 32'h8000_0000, ramp, 1'b0);
        wait_valid(ok);
        @(posedge clk); #1;
        core_enable = 1'b0;
        @(posedge clk); @(negedge clk);
        check("drop_valid", 64'(gene_valid), 64'd0);
        check("drop_active", 64'(seq_active), 64'd0);
        sd = 32'hCAFE_0001;
        push_expected(sd, ramp, 5);
        start_run(sd, 32'h8000_0000, ramp, 1'b0);
        gene_ready = 1'b1;
        drain(400, 1'b0);
        stop_run();

        // Reset mid-run with enable held high: no restart without a fresh edge.
        push_expected(32'h5, ramp, 100);
        start_run(32'h5, 32'h8000_0000, ramp, 1'b0);
        gene_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (seq_active || gene_valid) bad = 1'b1;
        end
        check("no_start_after_reset", 64'(bad), 64'd0);
        d = {8{$urandom}};
        push_expected(32'h77, d, 6);
        start_run(32'h77, 32'h8000_0000, d, 1'b0);
        gene_ready = 1'b1;
        drain(400, 1'b0);
        stop_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
